// File: rtl/lut_ram_pkg.sv
// Shared types and helpers for the self-loading lookup RAM with auto-scan.
package lut_ram_pkg;

  localparam int RD_LAT_MAX = 2;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_SCAN = 2'd2
  } state_t;

  // Default table entry: descending from DEPTH-1, masked to dw bits; wider words zero-extend.
  function automatic logic [31:0] init_val(input int idx, input int dw, input int aw);
    logic [31:0] full;
    full = 32'((1 << aw) - 1 - idx);
    if (dw < 32) full = full & ((32'd1 << dw) - 32'd1);
    return full;
  endfunction

endpackage

// File: rtl/lut_ram_rdpipe.sv
// Read-return delay line: carries {valid, last, addr, data} through LAT register stages.
module lut_ram_rdpipe #(
  parameter int DW  = 4,
  parameter int AW  = 4,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  input  logic          i_last,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  output logic          o_last,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data,
  output logic          o_lastInFlight
);

  logic          r_valid [LAT];
  logic          r_last  [LAT];
  logic [AW-1:0] r_addr  [LAT];
  logic [DW-1:0] r_data  [LAT];

  // Address/data only advance with a valid beat, so the output holds its last value when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) begin
        r_valid[k] <= 1'b0;
        r_last[k]  <= 1'b0;
        r_addr[k]  <= '0;
        r_data[k]  <= '0;
      end
    end else begin
      r_valid[0] <= i_valid;
      r_last[0]  <= i_valid & i_last;
      if (i_valid) begin
        r_addr[0] <= i_addr;
        r_data[0] <= i_data;
      end
      for (int k = 1; k < LAT; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_last[k]  <= r_valid[k-1] & r_last[k-1];
        if (r_valid[k-1]) begin
          r_addr[k] <= r_addr[k-1];
          r_data[k] <= r_data[k-1];
        end
      end
    end
  end

  always_comb begin
    o_lastInFlight = 1'b0;
    for (int k = 0; k < LAT; k++) o_lastInFlight = o_lastInFlight | r_last[k];
  end

  assign o_valid = r_valid[LAT-1];
  assign o_last  = r_last[LAT-1];
  assign o_addr  = r_addr[LAT-1];
  assign o_data  = r_data[LAT-1];

endmodule

// File: rtl/lut_ram_scan.sv
// Single-port lookup RAM that self-loads a descending table after reset and can
// stream the whole table out in address order on request.
module lut_ram_scan
  import lut_ram_pkg::*;
#(
  parameter int DW     = 4,
  parameter int AW     = 4,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] address,
  input  logic [DW-1:0] din,
  input  logic          scan_start,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic [AW-1:0] dout_addr,
  output logic          busy,
  output logic          scan_done
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] PTR_END = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_badLat
    $error("lut_ram_scan: RD_LAT must be 1 or 2");
  end

  state_t        r_state;
  logic [AW:0]   r_initPtr;
  logic [AW:0]   r_scanPtr;
  logic [DW-1:0] r_mem [DEPTH];

  logic          w_ready;
  logic          w_hostRead;
  logic          w_hostWrite;
  logic          w_rdValid;
  logic          w_rdLast;
  logic          w_lastInFlight;
  logic          w_memWe;
  logic [AW:0]   w_initNext;
  logic [AW:0]   w_scanNext;
  logic [AW-1:0] w_rdAddr;
  logic [AW-1:0] w_memAddr;
  logic [DW-1:0] w_rdData;
  logic [DW-1:0] w_memWdata;

  // Host traffic and scan requests are accepted only once the final scan beat has drained.
  assign w_ready     = (r_state == ST_IDLE) && !w_lastInFlight;
  assign w_hostRead  = w_ready && en && !we && !scan_start;
  assign w_hostWrite = w_ready && en && we && !scan_start;
  assign w_initNext  = r_initPtr + PTR_ONE;
  assign w_scanNext  = r_scanPtr + PTR_ONE;
  assign w_rdValid   = w_hostRead || (r_state == ST_SCAN);
  assign w_rdLast    = (r_state == ST_SCAN) && (w_scanNext == PTR_END);
  assign w_rdAddr    = (r_state == ST_SCAN) ? r_scanPtr[AW-1:0] : address;
  assign w_rdData    = r_mem[w_rdAddr];
  assign busy        = !w_ready;

  always_comb begin
    w_memWe    = 1'b0;
    w_memAddr  = address;
    w_memWdata = din;
    if (!rst) begin
      if (r_state == ST_INIT) begin
        w_memWe    = 1'b1;
        w_memAddr  = r_initPtr[AW-1:0];
        w_memWdata = DW'(init_val(int'(r_initPtr), DW, AW));
      end else if (w_hostWrite) begin
        w_memWe = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_memWe) r_mem[w_memAddr] <= w_memWdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_INIT;
      r_initPtr <= '0;
      r_scanPtr <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_initPtr <= w_initNext;
          if (w_initNext == PTR_END) r_state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (w_ready && scan_start) begin
            r_state   <= ST_SCAN;
            r_scanPtr <= '0;
          end
        end
        ST_SCAN: begin
          r_scanPtr <= w_scanNext;
          if (w_scanNext == PTR_END) r_state <= ST_IDLE;
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  lut_ram_rdpipe #(
    .DW  (DW),
    .AW  (AW),
    .LAT (RD_LAT)
  ) u_rdpipe (
    .clk            (clk),
    .rst            (rst),
    .i_valid        (w_rdValid),
    .i_last         (w_rdLast),
    .i_addr         (w_rdAddr),
    .i_data         (w_rdData),
    .o_valid        (dout_valid),
    .o_last         (scan_done),
    .o_addr         (dout_addr),
    .o_data         (dout),
    .o_lastInFlight (w_lastInFlight)
  );

endmodule

// File: tb/tb_lut_ram_scan.sv
// Self-checking bench: RD_LAT=1 and RD_LAT=2 instances driven in parallel against a table model.
module tb_lut_ram_scan;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       we = 1'b0;
  logic       scanStart = 1'b0;
  logic [3:0] address = '0;
  logic [3:0] din = '0;

  logic [3:0] dout1, addr1, dout2, addr2;
  logic       valid1, busy1, done1, valid2, busy2, done2;

  int nVec = 0;
  int nErr = 0;
  int model [DEPTH];

  always #5 clk = ~clk;

  lut_ram_scan #(.DW(4), .AW(4), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .we(we), .address(address), .din(din),
    .scan_start(scanStart), .dout(dout1), .dout_valid(valid1), .dout_addr(addr1),
    .busy(busy1), .scan_done(done1)
  );

  lut_ram_scan #(.DW(4), .AW(4), .RD_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .we(we), .address(address), .din(din),
    .scan_start(scanStart), .dout(dout2), .dout_valid(valid2), .dout_addr(addr2),
    .busy(busy2), .scan_done(done2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic e, input logic w, input logic [3:0] a,
                               input logic [3:0] d, input logic s);
    en = e; we = w; address = a; din = d; scanStart = s;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
  endtask

  // The power-on table: entry i holds DEPTH-1-i.
  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) model[i] = DEPTH - 1 - i;
  endtask

  task automatic pulseReset();
    idleInputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    modelReset();
  endtask

  task automatic waitReady(output int n);
    n = 0;
    while (busy1 && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    pulseReset();
    nVec++;
    if ({dout1, valid1, addr1, busy1, done1} !== {4'h0, 1'b0, 4'h0, 1'b1, 1'b0}) begin
      nErr++;
      $display("[TB] FAIL reset_state_lat1: got d=%h v=%b a=%h b=%b sd=%b, want d=0 v=0 a=0 b=1 sd=0",
               dout1, valid1, addr1, busy1, done1);
    end
    nVec++;
    if ({dout2, valid2, addr2, busy2, done2} !== {4'h0, 1'b0, 4'h0, 1'b1, 1'b0}) begin
      nErr++;
      $display("[TB] FAIL reset_state_lat2: got d=%h v=%b a=%h b=%b sd=%b, want d=0 v=0 a=0 b=1 sd=0",
               dout2, valid2, addr2, busy2, done2);
    end
    waitReady(n);
    nVec++;
    if (n != DEPTH) begin
      nErr++;
      $display("[TB] FAIL init_length: got %0d edges, want %0d", n, DEPTH);
    end
  endtask

  task automatic test_init_read();
    logic [3:0] a;
    applyStimulus(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
    step();
    nVec++;
    if ({valid1, addr1, dout1} !== {1'b1, 4'h0, 4'hF}) begin
      nErr++;
      $display("[TB] FAIL read0: got v=%b a=%h d=%h, want v=1 a=0 d=F", valid1, addr1, dout1);
    end
    applyStimulus(1'b1, 1'b0, 4'hF, 4'h0, 1'b0);
    step();
    idleInputs();
    nVec++;
    if ({valid1, addr1, dout1} !== {1'b1, 4'hF, 4'h0}) begin
      nErr++;
      $display("[TB] FAIL read15: got v=%b a=%h d=%h, want v=1 a=F d=0", valid1, addr1, dout1);
    end
    step();
    nVec++;
    if ({valid1, addr1, dout1} !== {1'b0, 4'hF, 4'h0}) begin
      nErr++;
      $display("[TB] FAIL valid_width_hold: got v=%b a=%h d=%h, want v=0 a=F d=0", valid1, addr1, dout1);
    end
    for (int k = 0; k < 8; k++) begin
      a = 4'($urandom_range(15));
      applyStimulus(1'b1, 1'b0, a, 4'h0, 1'b0);
      step();
      nVec++;
      if ({valid1, addr1, dout1, done1} !== {1'b1, a, 4'(model[a]), 1'b0}) begin
        nErr++;
        $display("[TB] FAIL rand_read: got v=%b a=%h d=%h sd=%b, want v=1 a=%h d=%h sd=0",
                 valid1, addr1, dout1, done1, a, 4'(model[a]));
      end
    end
    idleInputs();
  endtask

  task automatic test_busy_ignore();
    int n;
    logic sawValid;
    pulseReset();
    n = 0;
    sawValid = 1'b0;
    while (busy1 && n < 100) begin
      applyStimulus(1'b1, n[0], 4'h3, 4'($urandom), 1'b0);
      step();
      if (valid1) sawValid = 1'b1;
      n++;
    end
    idleInputs();
    nVec++;
    if (sawValid !== 1'b0 || n != DEPTH) begin
      nErr++;
      $display("[TB] FAIL busy_ignore: got valid_seen=%b edges=%0d, want valid_seen=0 edges=%0d",
               sawValid, n, DEPTH);
    end
    applyStimulus(1'b1, 1'b0, 4'h3, 4'h0, 1'b0);
    step();
    idleInputs();
    nVec++;
    if ({valid1, addr1, dout1} !== {1'b1, 4'h3, 4'hC}) begin
      nErr++;
      $display("[TB] FAIL read_after_init: got v=%b a=%h d=%h, want v=1 a=3 d=C", valid1, addr1, dout1);
    end
  endtask

  task automatic test_write_read();
    logic [3:0] a, d;
    applyStimulus(1'b1, 1'b1, 4'h5, 4'h3, 1'b0);
    step();
    model[5] = 3;
    nVec++;
    if (valid1 !== 1'b0) begin
      nErr++;
      $display("[TB] FAIL write_no_valid: got v=%b, want v=0", valid1);
    end
    applyStimulus(1'b1, 1'b0, 4'h5, 4'h0, 1'b0);
    step();
    nVec++;
    if ({valid1, dout1} !== {1'b1, 4'h3}) begin
      nErr++;
      $display("[TB] FAIL read5_after_write: got v=%b d=%h, want v=1 d=3", valid1, dout1);
    end
    applyStimulus(1'b1, 1'b0, 4'h6, 4'h0, 1'b0);
    step();
    nVec++;
    if ({valid1, dout1} !== {1'b1, 4'h9}) begin
      nErr++;
      $display("[TB] FAIL read6_after_write: got v=%b d=%h, want v=1 d=9", valid1, dout1);
    end
    for (int k = 0; k < 24; k++) begin
      a = 4'($urandom_range(15));
      d = 4'($urandom);
      if ($urandom_range(1) == 1) begin
        applyStimulus(1'b1, 1'b1, a, d, 1'b0);
        step();
        model[a] = int'(d);
        nVec++;
        if (valid1 !== 1'b0) begin
          nErr++;
          $display("[TB] FAIL rand_write_no_valid: got v=%b, want v=0", valid1);
        end
      end else begin
        applyStimulus(1'b1, 1'b0, a, 4'h0, 1'b0);
        step();
        nVec++;
        if ({valid1, addr1, dout1} !== {1'b1, a, 4'(model[a])}) begin
          nErr++;
          $display("[TB] FAIL rand_rw_read: got v=%b a=%h d=%h, want v=1 a=%h d=%h",
                   valid1, addr1, dout1, a, 4'(model[a]));
        end
      end
    end
    idleInputs();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 1'b0, 4'(i), 4'h0, 1'b0);
      step();
      nVec++;
      if ({valid1, addr1, dout1} !== {1'b1, 4'(i), 4'(model[i])}) begin
        nErr++;
        $display("[TB] FAIL stream_read: got v=%b a=%h d=%h, want v=1 a=%h d=%h",
                 valid1, addr1, dout1, 4'(i), 4'(model[i]));
      end
    end
    idleInputs();
  endtask

  task automatic test_scan();
    applyStimulus(1'b1, 1'b0, 4'h7, 4'h0, 1'b1);
    step();
    nVec++;
    if ({valid1, busy1} !== {1'b0, 1'b1}) begin
      nErr++;
      $display("[TB] FAIL scan_entry: got v=%b b=%b, want v=0 b=1", valid1, busy1);
    end
    for (int i = 0; i < DEPTH; i++) begin
      // Host writes, reads and a second scan_start during the scan must all be dropped.
      applyStimulus(1'b1, 1'(i % 2), 4'(i * 3), 4'($urandom), 1'(i == 4));
      step();
      nVec++;
      if ({valid1, addr1, dout1, done1, busy1} !== {1'b1, 4'(i), 4'(model[i]), 1'(i == DEPTH - 1), 1'b1}) begin
        nErr++;
        $display("[TB] FAIL scan_beat%0d: got v=%b a=%h d=%h sd=%b b=%b, want v=1 a=%h d=%h sd=%b b=1",
                 i, valid1, addr1, dout1, done1, busy1, 4'(i), 4'(model[i]), i == DEPTH - 1);
      end
      if (i == DEPTH - 2) idleInputs();
    end
    idleInputs();
    step();
    nVec++;
    if ({valid1, busy1, done1} !== 3'b000) begin
      nErr++;
      $display("[TB] FAIL scan_end: got v=%b b=%b sd=%b, want v=0 b=0 sd=0", valid1, busy1, done1);
    end
    for (int k = 0; k < 3; k++) step();
    nVec++;
    if (valid1 !== 1'b0) begin
      nErr++;
      $display("[TB] FAIL scan_no_requeue: got v=%b, want v=0", valid1);
    end
  endtask

  task automatic test_reset_midscan();
    int n;
    applyStimulus(1'b1, 1'b1, 4'h5, 4'h3, 1'b0);
    step();
    model[5] = 3;
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
    step();
    idleInputs();
    for (int i = 0; i < 8; i++) begin
      step();
      nVec++;
      if ({valid1, addr1, dout1} !== {1'b1, 4'(i), 4'(model[i])}) begin
        nErr++;
        $display("[TB] FAIL midscan_beat%0d: got v=%b a=%h d=%h, want v=1 a=%h d=%h",
                 i, valid1, addr1, dout1, 4'(i), 4'(model[i]));
      end
    end
    pulseReset();
    nVec++;
    if ({dout1, valid1, addr1, busy1, done1} !== {4'h0, 1'b0, 4'h0, 1'b1, 1'b0}) begin
      nErr++;
      $display("[TB] FAIL midscan_reset: got d=%h v=%b a=%h b=%b sd=%b, want d=0 v=0 a=0 b=1 sd=0",
               dout1, valid1, addr1, busy1, done1);
    end
    waitReady(n);
    applyStimulus(1'b1, 1'b0, 4'h5, 4'h0, 1'b0);
    step();
    idleInputs();
    nVec++;
    if ({n == DEPTH, valid1, dout1} !== {1'b1, 1'b1, 4'hA}) begin
      nErr++;
      $display("[TB] FAIL midscan_reinit: got edges=%0d v=%b d=%h, want edges=%0d v=1 d=A",
               n, valid1, dout1, DEPTH);
    end
  endtask

  task automatic test_rdlat2();
    int n;
    logic [3:0] q[$];
    logic [3:0] a, e;
    pulseReset();
    waitReady(n);
    nVec++;
    if (busy2 !== 1'b0 || n != DEPTH) begin
      nErr++;
      $display("[TB] FAIL lat2_ready: got b=%b edges=%0d, want b=0 edges=%0d", busy2, n, DEPTH);
    end
    applyStimulus(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
    step();
    nVec++;
    if (valid2 !== 1'b0) begin
      nErr++;
      $display("[TB] FAIL lat2_early: got v=%b, want v=0", valid2);
    end
    for (int i = 1; i <= 4; i++) begin
      if (i < 3) applyStimulus(1'b1, 1'b0, 4'(i), 4'h0, 1'b0);
      else idleInputs();
      step();
      nVec++;
      if (i < 4 && {valid2, addr2, dout2} !== {1'b1, 4'(i - 1), 4'(DEPTH - i)}) begin
        nErr++;
        $display("[TB] FAIL lat2_read%0d: got v=%b a=%h d=%h, want v=1 a=%h d=%h",
                 i - 1, valid2, addr2, dout2, 4'(i - 1), 4'(DEPTH - i));
      end else if (i == 4 && valid2 !== 1'b0) begin
        nErr++;
        $display("[TB] FAIL lat2_tail: got v=%b, want v=0", valid2);
      end
    end
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) begin
        a = 4'($urandom_range(15));
        q.push_back(a);
        applyStimulus(1'b1, 1'b0, a, 4'h0, 1'b0);
      end else begin
        idleInputs();
      end
      step();
      if (k >= 1) begin
        e = q.pop_front();
        nVec++;
        if ({valid2, addr2, dout2} !== {1'b1, e, 4'(model[e])}) begin
          nErr++;
          $display("[TB] FAIL lat2_stream: got v=%b a=%h d=%h, want v=1 a=%h d=%h",
                   valid2, addr2, dout2, e, 4'(model[e]));
        end
      end
    end
    // Let the RD_LAT=1 instance's stray beat drain so both sit idle before the scan.
    step();
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
    step();
    idleInputs();
    step();
    nVec++;
    if ({valid2, busy2} !== {1'b0, 1'b1}) begin
      nErr++;
      $display("[TB] FAIL lat2_scan_latency: got v=%b b=%b, want v=0 b=1", valid2, busy2);
    end
    for (int i = 0; i < DEPTH; i++) begin
      step();
      nVec++;
      if ({valid2, addr2, dout2, done2, busy2} !== {1'b1, 4'(i), 4'(model[i]), 1'(i == DEPTH - 1), 1'b1}) begin
        nErr++;
        $display("[TB] FAIL lat2_scan_beat%0d: got v=%b a=%h d=%h sd=%b b=%b, want v=1 a=%h d=%h sd=%b b=1",
                 i, valid2, addr2, dout2, done2, busy2, 4'(i), 4'(model[i]), i == DEPTH - 1);
      end
    end
    step();
    nVec++;
    if ({valid2, busy2, done2} !== 3'b000) begin
      nErr++;
      $display("[TB] FAIL lat2_scan_end: got v=%b b=%b sd=%b, want v=0 b=0 sd=0", valid2, busy2, done2);
    end
  endtask

  initial begin
    test_reset();
    test_init_read();
    test_busy_ignore();
    test_write_read();
    test_back_to_back();
    test_scan();
    test_back_to_back();
    test_reset_midscan();
    test_rdlat2();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule
